// File: rtl/pipe_ctrl.sv
// Pipeline control for the 5-stage MIPS core: stage stall arbitration, multi-cycle
// exception flush sequencing with redirect PC, stall/bubble counters and stall watchdog.
module pipe_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned TIMEOUT      = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_if,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic        flush_req,
  input  logic [31:0] flush_pc,
  input  logic        clr_cnt,
  output logic [5:0]  stop,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic [31:0] stall_cycles,
  output logic [31:0] bubble_cycles,
  output logic        stall_timeout
);

  localparam int unsigned WD_W   = $clog2(TIMEOUT + 1);
  localparam logic [3:0]  FC_INIT = 4'(FLUSH_CYCLES - 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_flush;
  logic              w_flush_nxt;
  logic [31:0]       r_new_pc;
  logic [31:0]       w_new_pc_nxt;
  logic [3:0]        r_fcnt;
  logic [3:0]        w_fcnt_nxt;
  logic [31:0]       r_stall_cycles;
  logic [31:0]       r_bubble_cycles;
  logic [WD_W-1:0]   r_wd_cnt;
  logic              r_stall_timeout;
  logic [5:0]        w_stop;
  logic              w_any_req;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    if (v == 32'hFFFF_FFFF) begin
      sat_inc = v;
    end else begin
      sat_inc = v + 32'd1;
    end
  endfunction

  assign w_any_req = stallreq_if | stallreq_id | stallreq_ex | stallreq_mem;

  // Highest requesting stage wins; an active flush overrides every stall.
  always_comb begin
    w_stop = 6'b000000;
    if (r_state == ST_FLUSH) begin
      w_stop = 6'b000000;
    end else if (stallreq_mem) begin
      w_stop = 6'b011111;
    end else if (stallreq_ex) begin
      w_stop = 6'b001111;
    end else if (stallreq_id) begin
      w_stop = 6'b000111;
    end else if (stallreq_if) begin
      w_stop = 6'b000011;
    end else begin
      w_stop = 6'b000000;
    end
  end

  // Flush sequencer: a new flush_req always re-arms with the latest PC.
  always_comb begin
    w_state_nxt  = r_state;
    w_flush_nxt  = r_flush;
    w_new_pc_nxt = r_new_pc;
    w_fcnt_nxt   = r_fcnt;
    case (r_state)
      ST_RUN: begin
        if (flush_req) begin
          w_state_nxt  = ST_FLUSH;
          w_flush_nxt  = 1'b1;
          w_new_pc_nxt = flush_pc;
          w_fcnt_nxt   = FC_INIT;
        end else begin
          w_state_nxt = ST_RUN;
          w_flush_nxt = 1'b0;
        end
      end
      ST_FLUSH: begin
        if (flush_req) begin
          w_flush_nxt  = 1'b1;
          w_new_pc_nxt = flush_pc;
          w_fcnt_nxt   = FC_INIT;
        end else if (r_fcnt == 4'd0) begin
          w_state_nxt = ST_RUN;
          w_flush_nxt = 1'b0;
        end else begin
          w_fcnt_nxt = r_fcnt - 4'd1;
        end
      end
      default: begin
        w_state_nxt = ST_RUN;
        w_flush_nxt = 1'b0;
        w_fcnt_nxt  = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_RUN;
      r_flush  <= 1'b0;
      r_new_pc <= 32'd0;
      r_fcnt   <= 4'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_flush  <= w_flush_nxt;
      r_new_pc <= w_new_pc_nxt;
      r_fcnt   <= w_fcnt_nxt;
    end
  end

  // Saturating performance counters; clear beats increment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cycles  <= 32'd0;
      r_bubble_cycles <= 32'd0;
    end else if (clr_cnt) begin
      r_stall_cycles  <= 32'd0;
      r_bubble_cycles <= 32'd0;
    end else begin
      if (w_stop[0]) begin
        r_stall_cycles <= sat_inc(r_stall_cycles);
      end else begin
        r_stall_cycles <= r_stall_cycles;
      end
      if (w_stop[2] && !w_stop[3]) begin
        r_bubble_cycles <= sat_inc(r_bubble_cycles);
      end else begin
        r_bubble_cycles <= r_bubble_cycles;
      end
    end
  end

  // Watchdog counts consecutive requesting cycles in RUN; the flag is sticky.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wd_cnt        <= '0;
      r_stall_timeout <= 1'b0;
    end else if (clr_cnt) begin
      r_wd_cnt        <= '0;
      r_stall_timeout <= 1'b0;
    end else if ((r_state == ST_RUN) && w_any_req) begin
      if (r_wd_cnt != WD_MAX) begin
        r_wd_cnt <= r_wd_cnt + WD_W'(1);
      end else begin
        r_wd_cnt <= r_wd_cnt;
      end
      if (r_wd_cnt >= (WD_MAX - WD_W'(1))) begin
        r_stall_timeout <= 1'b1;
      end else begin
        r_stall_timeout <= r_stall_timeout;
      end
    end else begin
      r_wd_cnt        <= '0;
      r_stall_timeout <= r_stall_timeout;
    end
  end

  assign stop          = w_stop;
  assign flush         = r_flush;
  assign new_pc        = r_new_pc;
  assign stall_cycles  = r_stall_cycles;
  assign bubble_cycles = r_bubble_cycles;
  assign stall_timeout = r_stall_timeout;

endmodule
